out_capture_fifo: RTL
=====================

Name: out_capture_fifo

Overview:
- Downstream consumer of the processor top's `out` bus.
- Samples the BIT_WIDTH-wide result stream each clock, either every enabled cycle or only when the value changes.
- Buffers samples in a first-word-fall-through FIFO and drains them over a valid/ready handshake to a host, display or bench scoreboard.
- Lets a program such as the 4-bit Fibonacci sequence be logged without per-cycle polling.

Parameters:
- BIT_WIDTH, 4, width of the captured data word; matches the processor datapath.
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- ADDR_WIDTH, 3, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- din  input  BIT_WIDTH  processor `out` bus.
- din_en  input  1  capture enable; samples are considered only when 1.
- cap_mode  input  1  0 = push every enabled cycle; 1 = push only on change.
- dout  output  BIT_WIDTH  head-of-FIFO data.
- dout_valid  output  1  head entry present.
- dout_ready  input  1  consumer accepts the head this cycle.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a sample was dropped.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset (rst == 0 at a rising edge):
  - Pointers and count go to 0; empty = 1, full = 0, dout_valid = 0, dout = 0, overflow = 0.
  - prev_valid = 0 and prev = 0.
  - Reset takes effect mid-operation: the FIFO is flushed and any push or pop in that cycle is ignored.
- Candidate sample:
  - cand = din_en && (cap_mode == 0 || !prev_valid || din != prev).
  - When din_en == 1: prev <= din and prev_valid <= 1, even if the sample is dropped.
  - The first enabled sample after reset is therefore always a candidate in change mode.
- Pop and push:
  - pop = dout_valid && dout_ready.
  - push = cand && (!full || pop). A full FIFO accepts a push in the same cycle as a pop; count is unchanged.
- Drop: cand && full && !pop drops the sample, sets overflow, and leaves the FIFO unchanged.
- Overflow clear: clr_ovf clears overflow on the next edge. If a drop and clr_ovf occur in the same cycle, set wins.
- Count update:
  - count += 1 on push-only.
  - count -= 1 on pop-only.
  - Unchanged on push+pop, or when neither occurs.
- Latency: a sample pushed at edge N appears on dout with dout_valid = 1 immediately after edge N, when the FIFO was empty.
- Empty FIFO: push+pop in the same cycle is not possible, because dout_valid = 0; there is no bypass.
- Output hold: dout and dout_valid stay stable while dout_valid && !dout_ready.
- Popping empty: no effect; count never underflows.
- Pointer wrap: read and write pointers wrap modulo DEPTH. full/empty are derived from count, not from pointer equality.
- dout content: dout = mem[rd_ptr] when valid, and holds its last value when empty.
- Timing: no combinational path from din or din_en to any output. dout_ready may affect only the next-state logic.

Optional Feature:
- Macro: OUT_CAPTURE_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 8-bit cycle counter; 0 at reset, +1 every cycle, wraps at 255.
  - Each pushed entry stores the counter value at its push edge.
  - New output dout_ts (8 bits) presents the head entry's timestamp, with the same valid/hold rules as dout; dout_ts = 0 at reset.
- Undefined: no counter, no timestamp storage, no dout_ts port. All other behaviour is identical.

Test Plan:
- Reset and basic push/pop:
  - Stimulus: rst = 0 for 2 cycles, then rst = 1; cap_mode = 0, din_en = 1, din = 5 for 1 cycle; dout_ready = 1 thereafter.
  - Required: after reset, empty = 1 and count = 0. After the push edge, dout = 5 and dout_valid = 1. After the next edge, empty = 1.
- Change mode:
  - Stimulus: cap_mode = 1; din sequence 0,1,1,2,3,3,5 with din_en = 1; dout_ready = 0.
  - Required: count = 5; drained order is 0,1,2,3,5.
- Full and overflow:
  - Stimulus: cap_mode = 0, dout_ready = 0; push 10 values 0..9.
  - Required: full = 1 with count = 8; overflow = 1; drain yields 0..7. Then clr_ovf = 1 for 1 cycle, after which overflow = 0.
- Full push+pop:
  - Stimulus: FIFO full with 0..7; one cycle with din = 9, din_en = 1, dout_ready = 1.
  - Required: count stays 8, overflow stays 0; full drain yields 1..7 then 9.
- Reset mid-stream and pointer wrap:
  - Stimulus: push/pop 20 alternating values 0..15 in wrap sequence, so the pointers wrap at least twice; then rst = 0 with 3 entries queued.
  - Required: data is in order throughout; after reset, count = 0, dout_valid = 0, prev_valid = 0, and the next change-mode sample is captured.
- Hold under backpressure:
  - Stimulus: dout_valid = 1 with dout = 3; dout_ready = 0 for 4 cycles while pushes continue.
  - Required: dout stays 3 throughout, and count increments by 1 per push.

Source files
------------

// File: rtl/out_capture_fifo.sv
// Captures the processor result bus into a first-word-fall-through FIFO; OUT_CAPTURE_TIMESTAMP_EN adds per-entry cycle stamps.
// Latency: a sample pushed into an empty FIFO is on dout right after its push edge.
// Backpressure: head holds while dout_ready is low; samples arriving when full are dropped and flagged.

module out_capture_fifo_core #(
  parameter int W          = 4,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          wdat,
  output logic [W-1:0]          rdat,
  output logic [ADDR_WIDTH:0]   count
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [W-1:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr_nxt;
  logic [ADDR_WIDTH:0]     count_nxt;
  logic [ADDR_WIDTH:0]     remaining;
  logic [W-1:0]            rdat_nxt;
  logic                    pop_ok;
  logic                    push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != DEPTH_C) || pop_ok);

  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      mem[wr_ptr] <= wdat;
    end
  end

  // Head is registered so the output never depends combinationally on the write side.
  always_comb begin
    rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(pop_ok);
    remaining  = count - (ADDR_WIDTH+1)'(pop_ok);
    rdat_nxt   = rdat;
    if (remaining != '0) begin
      rdat_nxt = mem[rd_ptr_nxt];
    end else if (push_ok) begin
      rdat_nxt = wdat;
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdat   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      rdat   <= rdat_nxt;
    end
  end
endmodule

module out_capture_fifo #(
  parameter int BIT_WIDTH  = 4,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIT_WIDTH-1:0]  din,
  input  logic                  din_en,
  input  logic                  cap_mode,
  output logic [BIT_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  clr_ovf
`ifdef OUT_CAPTURE_TIMESTAMP_EN
  ,
  output logic [7:0]            dout_ts
`endif
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
`ifdef OUT_CAPTURE_TIMESTAMP_EN
  localparam int FW = BIT_WIDTH + 8;
`else
  localparam int FW = BIT_WIDTH;
`endif

  logic [BIT_WIDTH-1:0] prev;
  logic                 prev_valid;
  logic                 cand;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [FW-1:0]        wdat;
  logic [FW-1:0]        rdat;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign dout_valid = !empty;

  // The first enabled sample after reset always counts as a change.
  assign cand = din_en && (!cap_mode || !prev_valid || (din != prev));
  assign pop  = dout_valid && dout_ready;
  assign push = cand && (!full || pop);
  assign drop = cand && full && !pop;

`ifdef OUT_CAPTURE_TIMESTAMP_EN
  logic [7:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 8'd1;
    end
  end

  assign wdat    = {ts_cnt, din};
  assign dout_ts = rdat[FW-1:BIT_WIDTH];
`else
  assign wdat = din;
`endif
  assign dout = rdat[BIT_WIDTH-1:0];

  out_capture_fifo_core #(
    .W          (FW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdat  (wdat),
    .rdat  (rdat),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (din_en) begin
      prev       <= din;
      prev_valid <= 1'b1;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end
endmodule
